// File: rtl/universal_shift_reg_if.sv
// Control, data and status bundle for the universal shift register.
// The master drives operation requests; the slave (the register) returns contents and status.
interface universal_shift_reg_if #(
  parameter int unsigned DW = 4,
  parameter int unsigned LW = 4
);
  logic          load;
  logic [DW-1:0] data;
  logic          en;
  logic [2:0]    mode;
  logic          sin_lsb;
  logic          sin_msb;
  logic          start;
  logic [LW-1:0] len;
  logic [DW-1:0] q;
  logic          sout_msb;
  logic          sout_lsb;
  logic          busy;
  logic          done;

  modport master (
    output load, data, en, mode, sin_lsb, sin_msb, start, len,
    input  q, sout_msb, sout_lsb, busy, done
  );

  modport slave (
    input  load, data, en, mode, sin_lsb, sin_msb, start, len,
    output q, sout_msb, sout_lsb, busy, done
  );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal shift register: logical/rotate/arithmetic shifts, parallel load, single-step
// shifting and an autonomous counted burst with a busy/done handshake.
module universal_shift_reg #(
  parameter int unsigned DW = 4,
  parameter int unsigned LW = 4
) (
  input logic                     clk,
  input logic                     async_rst_n,
  universal_shift_reg_if.slave    bus
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  localparam logic [2:0] OpSll = 3'd0;
  localparam logic [2:0] OpSrl = 3'd1;
  localparam logic [2:0] OpRol = 3'd2;
  localparam logic [2:0] OpRor = 3'd3;
  localparam logic [2:0] OpAsr = 3'd4;

  logic [0:0]    state_q, state_d;
  logic [DW-1:0] q_q, q_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [2:0]    burst_mode_q, burst_mode_d;
  logic          done_q, done_d;

  // One shift step; unused encodings hold the value.
  function automatic logic [DW-1:0] shift_step(input logic [2:0]    op,
                                               input logic [DW-1:0] v,
                                               input logic          sl,
                                               input logic          sm);
    logic [DW-1:0] r;
    r = v;
    case (op)
      OpSll:   r = {v[DW-2:0], sl};
      OpSrl:   r = {sm, v[DW-1:1]};
      OpRol:   r = {v[DW-2:0], v[DW-1]};
      OpRor:   r = {v[0], v[DW-1:1]};
      OpAsr:   r = {v[DW-1], v[DW-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    q_d          = q_q;
    cnt_d        = cnt_q;
    burst_mode_d = burst_mode_q;
    done_d       = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.load) begin
          q_d = bus.data;
        end else if (bus.start) begin
          if (bus.len == '0) begin
            // Empty burst still completes the handshake.
            done_d = 1'b1;
          end else begin
            q_d          = shift_step(bus.mode, q_q, bus.sin_lsb, bus.sin_msb);
            burst_mode_d = bus.mode;
            cnt_d        = bus.len - LW'(1);
            if (bus.len == LW'(1)) begin
              done_d = 1'b1;
            end else begin
              state_d = StBusy;
            end
          end
        end else if (bus.en) begin
          q_d = shift_step(bus.mode, q_q, bus.sin_lsb, bus.sin_msb);
        end
      end

      StBusy: begin
        if (bus.load) begin
          // Abort: no completion pulse.
          q_d     = bus.data;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          q_d   = shift_step(burst_mode_q, q_q, bus.sin_lsb, bus.sin_msb);
          cnt_d = cnt_q - LW'(1);
          if (cnt_q == LW'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q      <= StIdle;
      q_q          <= '0;
      cnt_q        <= '0;
      burst_mode_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      q_q          <= q_d;
      cnt_q        <= cnt_d;
      burst_mode_q <= burst_mode_d;
      done_q       <= done_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.sout_msb = q_q[DW-1];
  assign bus.sout_lsb = q_q[0];
  assign bus.busy     = (state_q == StBusy);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg: a behavioural model pushes the expected
// register state at each edge; the observed state is popped and compared just after it.
module tb_universal_shift_reg;
  localparam int DW = 4;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic async_rst_n;

  universal_shift_reg_if #(.DW(DW), .LW(LW)) bus ();

  universal_shift_reg #(.DW(DW), .LW(LW)) dut (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] q;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int busy_cycles = 0;

  logic [DW-1:0] m_q;
  logic          m_busy;
  logic          m_done;
  int            m_rem;
  logic [2:0]    m_mode;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_step(input logic [2:0] m, input logic [DW-1:0] v,
                                             input logic sl, input logic sm);
    logic [DW-1:0] r;
    case (m)
      3'd0:    r = (v << 1) | DW'(sl);
      3'd1:    r = (v >> 1) | (DW'(sm) << (DW - 1));
      3'd2:    r = (v << 1) | (v >> (DW - 1));
      3'd3:    r = (v >> 1) | (v << (DW - 1));
      3'd4:    r = DW'($signed(v) >>> 1);
      default: r = v;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_q    = '0;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_rem  = 0;
    m_mode = '0;
  endtask

  task automatic model_edge();
    logic nd;
    nd = 1'b0;
    if (!m_busy) begin
      if (bus.load) begin
        m_q = bus.data;
      end else if (bus.start) begin
        if (bus.len == 0) begin
          nd = 1'b1;
        end else begin
          m_q    = ref_step(bus.mode, m_q, bus.sin_lsb, bus.sin_msb);
          m_mode = bus.mode;
          m_rem  = int'(bus.len) - 1;
          if (m_rem == 0) nd = 1'b1;
          else            m_busy = 1'b1;
        end
      end else if (bus.en) begin
        m_q = ref_step(bus.mode, m_q, bus.sin_lsb, bus.sin_msb);
      end
    end else begin
      if (bus.load) begin
        m_q    = bus.data;
        m_busy = 1'b0;
        m_rem  = 0;
      end else begin
        m_q = ref_step(m_mode, m_q, bus.sin_lsb, bus.sin_msb);
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0;
          nd     = 1'b1;
        end
      end
    end
    m_done = nd;
  endtask

  task automatic tick();
    exp_t e;
    model_edge();
    sb_q.push_back('{q: m_q, busy: m_busy, done: m_done});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_val("q", 32'(bus.q), 32'(e.q));
    check_val("busy", 32'(bus.busy), 32'(e.busy));
    check_val("done", 32'(bus.done), 32'(e.done));
    check_val("sout_msb", 32'(bus.sout_msb), 32'(e.q[DW-1]));
    check_val("sout_lsb", 32'(bus.sout_lsb), 32'(e.q[0]));
    check_val("busy_done_excl", 32'(bus.busy & bus.done), 32'd0);
    if (bus.busy) busy_cycles++;
  endtask

  task automatic set_idle();
    bus.load  = 1'b0;
    bus.start = 1'b0;
    bus.en    = 1'b0;
  endtask

  task automatic do_load(input logic [DW-1:0] d);
    bus.load = 1'b1;
    bus.data = d;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic run_burst(input logic [2:0] m, input logic [LW-1:0] n);
    int g;
    g = 0;
    bus.mode  = m;
    bus.len   = n;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (m_busy && g < 40) begin
      tick();
      g++;
    end
    check_val("burst_done", 32'(bus.done), 32'd1);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    async_rst_n = 1'b0;
    #1;
    model_reset();
    check_val("rst_q", 32'(bus.q), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    set_idle();
    @(negedge clk);
    async_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    async_rst_n = 1'b0;
    set_idle();
    bus.data    = '0;
    bus.mode    = '0;
    bus.sin_lsb = 1'b0;
    bus.sin_msb = 1'b0;
    bus.len     = '0;
    model_reset();
    #2;
    check_val("reset_q", 32'(bus.q), 32'd0);
    check_val("reset_busy", 32'(bus.busy), 32'd0);
    check_val("reset_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    async_rst_n = 1'b1;

    // Load then hold.
    do_load(4'b1011);
    check_val("load_1011", 32'(bus.q), 32'b1011);
    repeat (3) tick();

    // Single-step shifts.
    bus.mode = 3'd0; bus.sin_lsb = 1'b0; bus.en = 1'b1;
    tick(); check_val("sll_1", 32'(bus.q), 32'b0110);
    tick(); check_val("sll_2", 32'(bus.q), 32'b1100);
    bus.mode = 3'd1; bus.sin_msb = 1'b1;
    tick(); check_val("srl_1", 32'(bus.q), 32'b1110);
    bus.mode = 3'd5;
    tick(); tick(); check_val("mode5_hold", 32'(bus.q), 32'b1110);
    bus.en = 1'b0;

    // Rotate burst; mode input toggles while busy.
    do_load(4'b1011);
    busy_cycles = 0;
    bus.mode = 3'd3; bus.len = 4'd5; bus.start = 1'b1;
    tick();
    check_val("ror_step1", 32'(bus.q), 32'b1101);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mode = 3'(i);
      tick();
    end
    check_val("ror_final", 32'(bus.q), 32'b1101);
    check_val("ror_done", 32'(bus.done), 32'd1);
    check_val("ror_busy_cycles", 32'(busy_cycles), 32'd4);
    tick();

    // Arithmetic and logical bursts.
    do_load(4'b1000);
    run_burst(3'd4, 4'd2);
    check_val("asr_final", 32'(bus.q), 32'b1110);
    do_load(4'b0000);
    bus.sin_msb = 1'b1;
    run_burst(3'd1, 4'd3);
    check_val("srl_final", 32'(bus.q), 32'b1110);

    // Abort by load at second busy cycle.
    do_load(4'b0001);
    bus.sin_lsb = 1'b0;
    bus.mode = 3'd0; bus.len = 4'd4; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.load = 1'b1; bus.data = 4'b0101;
    tick();
    bus.load = 1'b0;
    check_val("abort_q", 32'(bus.q), 32'b0101);
    check_val("abort_busy", 32'(bus.busy), 32'd0);
    tick();
    check_val("abort_no_done", 32'(bus.done), 32'd0);

    // Reset mid-burst.
    do_load(4'b0001);
    bus.mode = 3'd0; bus.len = 4'd4; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    async_reset();
    tick();

    // len=0: no shift, done only.
    do_load(4'b1010);
    busy_cycles = 0;
    run_burst(3'd0, 4'd0);
    check_val("len0_q", 32'(bus.q), 32'b1010);
    check_val("len0_busy", 32'(busy_cycles), 32'd0);
    tick();

    // len=1: one shift, done next cycle.
    bus.sin_lsb = 1'b1;
    run_burst(3'd0, 4'd1);
    check_val("len1_q", 32'(bus.q), 32'b0101);
    check_val("len1_busy", 32'(busy_cycles), 32'd0);
    tick();

    // len=15 with start/en pulses while busy.
    do_load(4'b1011);
    busy_cycles = 0;
    bus.mode = 3'd2; bus.len = 4'd15; bus.start = 1'b1;
    tick();
    bus.len = 4'd3; bus.en = 1'b1; bus.mode = 3'd1;
    tick(); tick();
    set_idle();
    for (int i = 0; i < 20 && m_busy; i++) tick();
    check_val("len15_busy_cycles", 32'(busy_cycles), 32'd14);
    check_val("len15_done", 32'(bus.done), 32'd1);
    tick();

    // Back-to-back start during the done cycle.
    do_load(4'b0011);
    run_burst(3'd2, 4'd2);
    bus.sin_lsb = 1'b0;
    run_burst(3'd0, 4'd3);
    check_val("b2b_final", 32'(bus.q), 32'b0000);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
Parametrised universal shift register, successor to the single-direction left shifter. It supports left/right logical shift, rotate, arithmetic right shift, parallel load, and single-step shifting under en. It also runs an autonomous burst mode that performs a programmed number of shifts with a busy/done handshake. It sits in serial-conversion and bit-manipulation datapaths in the register library.

Parameters:
DW, 4, register width in bits (>=2)
LW, 4, width of burst length input; max burst = 2**LW-1 shifts

Ports:
clk  input  1  clock, rising-edge active
async_rst_n  input  1  reset, asynchronous, active-low
load  input  1  parallel load strobe, highest synchronous priority
data  input  DW  parallel load value
en  input  1  single-step shift enable (idle only)
mode  input  3  shift operation select
sin_lsb  input  1  serial bit entering LSB on left shift
sin_msb  input  1  serial bit entering MSB on logical right shift
start  input  1  burst start request (idle only)
len  input  LW  burst shift count, sampled with start
q  output  DW  register contents
sout_msb  output  1  equals q[DW-1]
sout_lsb  output  1  equals q[0]
busy  output  1  burst in progress
done  output  1  one-cycle pulse at burst completion

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low (async_rst_n).
- Reset (async_rst_n=0, immediate, no clock needed): q=0, busy=0, done=0, internal counter=0, latched mode=0, FSM=IDLE. Reset mid-burst aborts the burst without a done pulse.
- Mode encoding (one shift step):
  - 0 SLL: q<={q[DW-2:0],sin_lsb}
  - 1 SRL: q<={sin_msb,q[DW-1:1]}
  - 2 ROL: q<={q[DW-2:0],q[DW-1]}
  - 3 ROR: q<={q[0],q[DW-1:1]}
  - 4 ASR: q<={q[DW-1],q[DW-1:1]}
  - 5,6,7: hold (q unchanged)
- Serial inputs are sampled live at every shift edge, including during bursts.
- FSM has two states, IDLE and BUSY.
- IDLE priority per edge: load > start > en > hold.
  - load=1: q<=data. start and en are ignored.
  - start=1, len>=1: q<=one step of mode; latch mode into burst_mode; cnt<=len-1.
    - If len==1: stay IDLE, done=1 next cycle.
    - Else: go BUSY, busy=1.
  - start=1, len==0: q unchanged, done=1 for one cycle, busy stays 0.
  - en=1 only: q<=one step of mode. No busy/done activity.
- BUSY, each edge:
  - load=1: q<=data, go IDLE, busy=0, cnt=0, no done (abort).
  - Else: q<=one step of burst_mode; the mode input is ignored. cnt<=cnt-1.
  - When cnt==1 at the edge: go IDLE, busy=0, done=1 for the following cycle.
  - start and en are ignored while BUSY.
- Latency: a burst of len=N started at edge k shifts at edges k..k+N-1.
  - busy is high from after edge k to after edge k+N-1 (N-1 cycles).
  - done is high for exactly one cycle after edge k+N-1, coincident with the final q.
- done is registered and a single-cycle pulse. It is never asserted with busy=1.
- A new start is accepted in the same cycle done is high; done then re-pulses per the new burst.
- sout_msb/sout_lsb are combinational from q and reflect the current register value.
- All outputs are registered except sout_*.

Test Plan:
- Reset/load, DW=4: assert async_rst_n=0 between edges -> q=0000 immediately. Release, load data=1011 -> q=1011 after next edge; en=0 -> holds over 3 cycles.
- Single-step: q=1011, en=1, mode=0, sin_lsb=0 for 2 edges -> 0110 then 1100. Then mode=1, sin_msb=1 -> 1110. Mode=5 -> hold at 1110.
- Rotate burst: q=1011, start=1, mode=3, len=5 -> busy=1 for 4 cycles, done=1 for one cycle. Final q=1101; intermediates are 1101, 1110, 0111, 1011, 1101. Toggling mode during the burst has no effect.
- Arithmetic/logical burst: q=1000, mode=4, len=2 -> q=1110, done pulse. Then q=0000, mode=1, sin_msb=1, len=3 -> q=1110.
- Abort cases:
  - q=0001, mode=0, sin_lsb=0, len=4: load data=0101 at the 2nd busy cycle -> q=0101, busy=0, no done.
  - Repeat the burst, then pull async_rst_n low mid-burst -> q=0, busy=0, done=0 immediately.
- Boundaries:
  - len=0 start -> q unchanged, done one cycle, busy never high.
  - len=1 -> one shift, done next cycle, busy never high.
  - len=15 (max) -> 15 shifts, busy 14 cycles.
  - start while BUSY is ignored.
  - Back-to-back start during the done cycle is accepted.
